// File: rtl/alink_tx_sched_pkg.sv
// Shared constants and types for the Alink transmit scheduler.
// Holds FSM state encodings, default task size and PHY lane count.
package alink_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_e;

    localparam int SCHED_TASK_WORDS = 24;
    localparam int ALINK_PHY_NUM    = 32;
    localparam int SEL_W            = 32;

    function automatic logic [4:0] onehot_to_idx(input logic [SEL_W-1:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < SEL_W; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/alink_tx_sched_rr_pick.sv
// Rotating priority encoder: grants the first eligible lane strictly after
// rr_ptr, wrapping from PHY_NUM-1 back to lane 0.
module alink_tx_sched_rr_pick
    import alink_tx_sched_pkg::*;
#(
    parameter int PHY_NUM = ALINK_PHY_NUM
) (
    input  logic [PHY_NUM-1:0] eligible,
    input  logic [4:0]         rr_ptr,
    output logic [PHY_NUM-1:0] grant,
    output logic               valid
);

    localparam int IDX_W = (PHY_NUM > 1) ? $clog2(PHY_NUM) : 1;

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= PHY_NUM; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % PHY_NUM);
            if (!valid && eligible[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alink_tx_sched.sv
// Alink transmit scheduler: round-robin PHY selection and start/select issue.
// Optional WAIT watchdog enabled by defining TX_SCHED_WDOG_EN.
module alink_tx_sched
    import alink_tx_sched_pkg::*;
#(
    parameter int PHY_NUM     = ALINK_PHY_NUM,
    parameter int TASK_WORDS  = SCHED_TASK_WORDS,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               reg_en,
    input  logic               reg_flush,
    input  logic [PHY_NUM-1:0] reg_phy_mask,
    input  logic [9:0]         tx_fifo_cnt,
    input  logic [PHY_NUM-1:0] phy_busy_clr,
    output logic               tx_phy_start,
    output logic [SEL_W-1:0]   tx_phy_sel,
    input  logic               tx_phy_done,
    output logic [PHY_NUM-1:0] phy_busy,
    output logic [31:0]        sched_cnt,
    output logic               sched_err
);

    sched_state_e       state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               start_q, start_d;
    logic [PHY_NUM-1:0] busy_q, busy_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [4:0]         ptr_q, ptr_d;

    logic [PHY_NUM-1:0] eligible;
    logic [PHY_NUM-1:0] grant;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_ext;
    logic               can_go;

`ifdef TX_SCHED_WDOG_EN
    localparam int WD_W = ($clog2(WDOG_CYCLES + 1) > 16) ? $clog2(WDOG_CYCLES + 1) : 16;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
`endif

    assign eligible = reg_phy_mask & ~busy_q;
    assign can_go   = reg_en && !reg_flush && (tx_fifo_cnt >= 10'(TASK_WORDS)) && grant_valid;

    alink_tx_sched_rr_pick #(
        .PHY_NUM (PHY_NUM)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (ptr_q),
        .grant    (grant),
        .valid    (grant_valid)
    );

    always_comb begin
        grant_ext              = '0;
        grant_ext[PHY_NUM-1:0] = grant;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        // Flush wipes every flag; a same-cycle set below still wins.
        busy_d  = reg_flush ? '0 : (busy_q & ~phy_busy_clr);
`ifdef TX_SCHED_WDOG_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (can_go) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                if (reg_flush || !grant_valid) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end else begin
                    state_d = ST_START;
                    sel_d   = grant_ext;
                    start_d = 1'b1;
                    busy_d  = busy_d | grant;
                    ptr_d   = onehot_to_idx(grant_ext);
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
`ifdef TX_SCHED_WDOG_EN
                wd_d    = '0;
`endif
            end
            ST_WAIT: begin
                if (tx_phy_done) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
`ifdef TX_SCHED_WDOG_EN
                end else if (wd_q == WD_W'(WDOG_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                    err_d   = 1'b1;
                    busy_d  = busy_d & ~sel_q[PHY_NUM-1:0];
                end else begin
                    wd_d    = wd_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= 5'(PHY_NUM - 1);
`ifdef TX_SCHED_WDOG_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
`ifdef TX_SCHED_WDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    assign tx_phy_start = start_q;
    assign tx_phy_sel   = sel_q;
    assign phy_busy     = busy_q;
    assign sched_cnt    = cnt_q;
`ifdef TX_SCHED_WDOG_EN
    assign sched_err    = err_q;
`else
    assign sched_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alink_tx_sched.sv
// Directed plus randomized bench for alink_tx_sched against a task-level model
// of round-robin choice, busy bookkeeping and issue count.
module tb_alink_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_en;
    logic        reg_flush;
    logic [31:0] reg_phy_mask;
    logic [9:0]  tx_fifo_cnt;
    logic [31:0] phy_busy_clr;
    logic        tx_phy_start;
    logic [31:0] tx_phy_sel;
    logic        tx_phy_done;
    logic [31:0] phy_busy;
    logic [31:0] sched_cnt;
    logic        sched_err;

    int          vecs = 0;
    int          errs = 0;

    // Reference model: which PHYs hold a task, last PHY served, tasks issued.
    logic [31:0] m_busy;
    int          m_ptr;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    alink_tx_sched #(
        .PHY_NUM     (32),
        .TASK_WORDS  (24),
        .WDOG_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_en       (reg_en),
        .reg_flush    (reg_flush),
        .reg_phy_mask (reg_phy_mask),
        .tx_fifo_cnt  (tx_fifo_cnt),
        .phy_busy_clr (phy_busy_clr),
        .tx_phy_start (tx_phy_start),
        .tx_phy_sel   (tx_phy_sel),
        .tx_phy_done  (tx_phy_done),
        .phy_busy     (phy_busy),
        .sched_cnt    (sched_cnt),
        .sched_err    (sched_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [31:0] mask);
        for (int k = 1; k <= 32; k++) begin
            int i;
            i = (m_ptr + k) % 32;
            if (mask[i] && !m_busy[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = '0;
        m_ptr  = 31;
        m_cnt  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_start", tx_phy_start, 0);
        chk("rst_sel",   tx_phy_sel,   0);
        chk("rst_busy",  phy_busy,     0);
        chk("rst_cnt",   sched_cnt,    0);
        chk("rst_err",   sched_err,    0);
        rst = 1'b0;
        model_reset();
    endtask

    // Called in an IDLE cycle whose inputs qualify; start must show 2 cycles later.
    task automatic start_expect(input string tag, input logic [31:0] pick_clr);
        int exp;
        exp = model_pick(reg_phy_mask);
        if (exp < 0) begin
            errs++;
            $error("FAIL %s_nopick observed=none expected=eligible", tag);
            exp = 0;
        end
        tick();
        chk({tag, "_pick_start"}, tx_phy_start, 0);
        phy_busy_clr = pick_clr;
        tick();
        phy_busy_clr = '0;
        m_busy = (m_busy & ~pick_clr) | (32'd1 << exp);
        m_ptr  = exp;
        m_cnt  = m_cnt + 32'd1;
        chk({tag, "_start"}, tx_phy_start, 1);
        chk({tag, "_sel"},   tx_phy_sel,   32'd1 << exp);
        chk({tag, "_busy"},  phy_busy,     m_busy);
        chk({tag, "_cnt"},   sched_cnt,    m_cnt);
    endtask

    // Called on the start cycle; waits n_wait cycles (>=1) then pulses done.
    task automatic finish_task(input string tag, input int n_wait, input bit rnd_clr);
        logic [31:0] sel_exp;
        logic [31:0] clr;
        sel_exp = 32'd1 << m_ptr;
        for (int w = 0; w < n_wait; w++) begin
            clr = rnd_clr ? ($urandom() & $urandom() & $urandom()) : 32'd0;
            phy_busy_clr = clr;
            tick();
            m_busy = m_busy & ~clr;
            chk({tag, "_wait_start"}, tx_phy_start, 0);
            chk({tag, "_wait_sel"},   tx_phy_sel,   sel_exp);
            chk({tag, "_wait_busy"},  phy_busy,     m_busy);
        end
        phy_busy_clr = '0;
        tx_phy_done  = 1'b1;
        tick();
        tx_phy_done  = 1'b0;
        chk({tag, "_done_sel"}, tx_phy_sel, 0);
        chk({tag, "_done_err"}, sched_err,  0);
        chk({tag, "_done_busy"}, phy_busy,  m_busy);
    endtask

    task automatic release_all();
        reg_en       = 1'b0;
        phy_busy_clr = '1;
        tick();
        phy_busy_clr = '0;
        m_busy       = '0;
        chk("release_busy", phy_busy, 0);
        reg_en       = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst          = 1'b1;
        reg_en       = 1'b0;
        reg_flush    = 1'b0;
        reg_phy_mask = '0;
        tx_fifo_cnt  = '0;
        phy_busy_clr = '0;
        tx_phy_done  = 1'b0;
        model_reset();
        do_reset();

        // Single task on PHY0.
        reg_phy_mask = 32'h1;
        tx_fifo_cnt  = 10'd24;
        reg_en       = 1'b1;
        start_expect("single", '0);
        finish_task("single", 2, 1'b0);
        release_all();

        // Round robin over four lanes, then starvation until a release.
        do_reset();
        reg_phy_mask = 32'hF;
        reg_en       = 1'b1;
        tx_fifo_cnt  = 10'd24;
        for (int i = 0; i < 4; i++) begin
            start_expect("rr", '0);
            finish_task("rr", 1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_full_start", tx_phy_start, 0);
            chk("rr_full_busy",  phy_busy,     32'hF);
        end
        phy_busy_clr = 32'hA;
        tick();
        phy_busy_clr = '0;
        m_busy = m_busy & ~32'hA;
        chk("wrap_busy", phy_busy, 32'h5);
        start_expect("wrap", '0);
        chk("wrap_sel_phy1", tx_phy_sel, 32'h2);
        finish_task("wrap", 1, 1'b0);
        start_expect("wrap3", '0);
        finish_task("wrap3", 1, 1'b0);
        phy_busy_clr = 32'h4;
        tick();
        phy_busy_clr = '0;
        m_busy = m_busy & ~32'h4;
        start_expect("setwins", 32'h4);
        chk("setwins_busy", phy_busy, 32'hF);
        finish_task("setwins", 1, 1'b0);
        release_all();

        // Clear on a non-busy lane is ignored.
        reg_en       = 1'b0;
        reg_phy_mask = 32'hF;
        tick();
        start_expect_guard: begin end
        reg_en = 1'b1;
        start_expect("pre_ign", '0);
        finish_task("pre_ign", 1, 1'b0);
        reg_en       = 1'b0;
        phy_busy_clr = 32'h20;
        tick();
        phy_busy_clr = '0;
        chk("ign_busy", phy_busy, m_busy);
        release_all();

        // FIFO underflow.
        tx_fifo_cnt = 10'd23;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("under_start", tx_phy_start, 0);
        end
        tx_fifo_cnt = 10'd24;
        start_expect("under", '0);
        finish_task("under", 1, 1'b0);

        // Flush while waiting.
        start_expect("flush", '0);
        tick();
        reg_flush = 1'b1;
        tick();
        m_busy = '0;
        chk("flush_busy",  phy_busy,     0);
        chk("flush_sel",   tx_phy_sel,   32'd1 << m_ptr);
        chk("flush_start", tx_phy_start, 0);
        tick();
        chk("flush_hold_sel", tx_phy_sel, 32'd1 << m_ptr);
        tx_phy_done = 1'b1;
        tick();
        tx_phy_done = 1'b0;
        chk("flush_done_sel", tx_phy_sel, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flush_nostart", tx_phy_start, 0);
        end
        reg_flush = 1'b0;
        start_expect("postflush", '0);
        finish_task("postflush", 1, 1'b0);

        // Enable dropped mid-task; stray done in IDLE is ignored.
        start_expect("endrop", '0);
        reg_en = 1'b0;
        finish_task("endrop", 3, 1'b0);
        tx_phy_done = 1'b1;
        tick();
        tx_phy_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("endrop_nostart", tx_phy_start, 0);
            chk("endrop_busy",    phy_busy,     m_busy);
        end
        chk("endrop_cnt", sched_cnt, m_cnt);
        release_all();

        // Reset in the middle of a task.
        start_expect("midrst", '0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_start", tx_phy_start, 0);
        chk("midrst_sel",   tx_phy_sel,   0);
        chk("midrst_busy",  phy_busy,     0);
        chk("midrst_cnt",   sched_cnt,    0);
        model_reset();
        start_expect("postrst", '0);
        chk("postrst_phy0", tx_phy_sel, 32'h1);
        finish_task("postrst", 1, 1'b0);

`ifdef TX_SCHED_WDOG_EN
        start_expect("wdog", '0);
        reg_en = 1'b0;
        n = 0;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (sched_err === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("wdog_cycle", n, 101);
        m_busy = m_busy & ~(32'd1 << m_ptr);
        chk("wdog_busy", phy_busy,   m_busy);
        chk("wdog_sel",  tx_phy_sel, 0);
        tick();
        chk("wdog_pulse", sched_err, 0);
        reg_en = 1'b1;
`endif

        // Randomized tasks against the model.
        for (int it = 0; it < 40; it++) begin
            reg_phy_mask = $urandom();
            if (it % 2 == 1) reg_phy_mask = reg_phy_mask & $urandom();
            if (reg_phy_mask == 0) reg_phy_mask = 32'h1;
            if (model_pick(reg_phy_mask) < 0) release_all();
            if ($urandom_range(0, 3) == 0) begin
                tx_fifo_cnt = 10'($urandom_range(0, 23));
                for (int i = 0; i < 2; i++) begin
                    tick();
                    chk("rnd_under_start", tx_phy_start, 0);
                end
            end
            tx_fifo_cnt = 10'($urandom_range(24, 1023));
            start_expect("rnd", $urandom() & $urandom() & $urandom());
            finish_task("rnd", $urandom_range(1, 4), 1'b1);
        end
        chk("final_cnt", sched_cnt, m_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
